image_send_select_fsm: RTL and testbench

Frame-gating controller between the camera capture path and the downstream image consumer (FFT / display). It periodically resets the capture pipeline, then lets exactly one frame through. After that frame it idles for a fixed hold period before the next reset. While a frame is in flight it forwards either the normal or the blurred pixel stream, chosen by the robot's top-level `state` latched at frame start.

---
 rtl/image_send_pkg.sv | 18 +
 rtl/cycle_timer.sv | 37 +++
 rtl/image_send_select_fsm.sv | 97 +++++++++
 tb/tb_image_send_select_fsm.sv | 137 +++++++++++++
 4 files changed

// File: rtl/image_send_pkg.sv
// Shared types and constants for the frame-gating controller.
// Holds the FSM state encoding, pixel width and a small length helper.
package image_send_pkg;

  localparam int PIX_W = 12;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_STREAM = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  // Lengths below one collapse to a single cycle.
  function automatic int clamp_len(input int len);
    return (len < 1) ? 1 : len;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counter that flags the last cycle of a programmable length; one cycle per count.
// No backpressure: counts whenever enabled, clear has priority over counting.
module cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_len,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // load_len is at least 1, so the last count is load_len-1.
  assign done = en && (cnt_q == (load_len - WIDTH'(1)));

endmodule

// File: rtl/image_send_select_fsm.sv
// Pulses the capture-pipeline reset, passes one frame, then holds before repeating.
// reset_signal is registered; data_out is a 0-cycle mux on the select latched at frame start.
module image_send_select_fsm
  import image_send_pkg::*;
#(
  parameter int          WAIT_TIME   = 10_000_000,
  parameter int          RESET_TIME  = 1_000_000,
  parameter logic [3:0]  TABLE_STATE = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] norm_in,
  input  logic [PIX_W-1:0] blur_in,
  input  logic [3:0]       state,
  input  logic             image_ready,
  output logic             reset_signal,
  output logic [PIX_W-1:0] data_out
);

  localparam int WAIT_LEN  = clamp_len(WAIT_TIME);
  localparam int RESET_LEN = clamp_len(RESET_TIME);
  localparam int MAX_LEN   = (WAIT_LEN > RESET_LEN) ? WAIT_LEN : RESET_LEN;
  localparam int CW        = $clog2(MAX_LEN + 1);

  state_e          state_q, state_d;
  logic            sel_blur_q, sel_blur_d;
  logic            reset_signal_q, reset_signal_d;
  logic            tmr_en;
  logic            tmr_clear;
  logic [CW-1:0]   tmr_len;
  logic            tmr_done;

  cycle_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tmr_en),
    .clear    (tmr_clear),
    .load_len (tmr_len),
    .done     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    sel_blur_d = sel_blur_q;
    tmr_en     = 1'b0;
    tmr_clear  = 1'b0;
    tmr_len    = CW'(RESET_LEN);
    case (state_q)
      S_RESET: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          sel_blur_d = (state == TABLE_STATE);
          tmr_clear  = 1'b1;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        // Counter parked at zero while a frame is in flight.
        tmr_clear = 1'b1;
        if (image_ready) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        tmr_en  = 1'b1;
        tmr_len = CW'(WAIT_LEN);
        if (tmr_done) begin
          tmr_clear = 1'b1;
          state_d   = S_RESET;
        end
      end
      default: begin
        tmr_clear = 1'b1;
        state_d   = S_RESET;
      end
    endcase
    reset_signal_d = (state_d == S_RESET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RESET;
      sel_blur_q     <= 1'b0;
      reset_signal_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      sel_blur_q     <= sel_blur_d;
      reset_signal_q <= reset_signal_d;
    end
  end

  assign reset_signal = reset_signal_q;
  assign data_out     = sel_blur_q ? blur_in : norm_in;

endmodule

// File: tb/tb_image_send_select_fsm.sv
// Directed bench for image_send_select_fsm with WAIT_TIME=8, RESET_TIME=4, TABLE_STATE=0.
module tb_image_send_select_fsm;

  logic        clk;
  logic        rst_n;
  logic [11:0] norm_in;
  logic [11:0] blur_in;
  logic [3:0]  state;
  logic        image_ready;
  logic        reset_signal;
  logic [11:0] data_out;

  int checks;
  int errors;

  image_send_select_fsm #(
    .WAIT_TIME   (8),
    .RESET_TIME  (4),
    .TABLE_STATE (4'b0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .norm_in      (norm_in),
    .blur_in      (blur_in),
    .state        (state),
    .image_ready  (image_ready),
    .reset_signal (reset_signal),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Starting on a negedge in S_STREAM: pulse image_ready, then walk HOLD (8) and RESET (4).
  task automatic run_frame(input logic [3:0] st_in_reset, input bit noise,
                           input logic [11:0] exp_dat);
    image_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      image_ready = noise && (i == 3);
      check("hold_rs", 12'(reset_signal), 12'h000);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_rs", 12'(reset_signal), 12'h001);
      if (i == 1) state = st_in_reset;
      image_ready = noise && (i == 0);
    end
    @(negedge clk);
    check("stream_rs", 12'(reset_signal), 12'h000);
    check("stream_dat", data_out, exp_dat);
    if (noise) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("wait_fresh_rs", 12'(reset_signal), 12'h000);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    state       = 4'h0;
    norm_in     = 12'hF0F;
    blur_in     = 12'h0F0;
    image_ready = 1'b0;

    // Power-up reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("por_rs", 12'(reset_signal), 12'h001);
      check("por_dat", data_out, 12'hF0F);
    end
    rst_n = 1'b1;
    check("rel_rs", 12'(reset_signal), 12'h001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rel_rs", 12'(reset_signal), 12'h001);
    end
    @(negedge clk);
    check("first_stream_rs", 12'(reset_signal), 12'h000);
    check("table_dat", data_out, 12'h0F0);

    // State change mid-frame must not switch streams.
    state = 4'h1;
    repeat (3) @(negedge clk);
    check("midframe_dat", data_out, 12'h0F0);
    check("midframe_rs", 12'(reset_signal), 12'h000);

    run_frame(4'h0, 1'b0, 12'h0F0);
    run_frame(4'h3, 1'b0, 12'hF0F);

    // Normal stream selected: output follows norm_in combinationally.
    norm_in = 12'h123;
    #1;
    check("comb_norm", data_out, 12'h123);
    norm_in = 12'hF0F;
    #1;

    run_frame(4'h0, 1'b1, 12'h0F0);

    // Async reset a few cycles into HOLD.
    @(negedge clk);
    image_ready = 1'b1;
    @(negedge clk);
    image_ready = 1'b0;
    check("hold_entry_rs", 12'(reset_signal), 12'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rs", 12'(reset_signal), 12'h001);
    check("async_dat", data_out, 12'hF0F);
    @(negedge clk);
    rst_n = 1'b1;
    check("async_rel_rs", 12'(reset_signal), 12'h001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("async_post_rs", 12'(reset_signal), 12'h001);
    end
    @(negedge clk);
    check("async_stream_rs", 12'(reset_signal), 12'h000);
    check("async_stream_dat", data_out, 12'h0F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
